// File: rtl/hs_token_fifo.sv
// Elastic req/ack token buffer. It acts as a consumer toward its upstream and as a producer
// toward its downstream. Define HS_FIFO_STATS_EN to add the tok_in/tok_out/max_occ counters.
module hs_token_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       in_req_o,
  input  logic                       in_ack_i,
  input  logic [DataWidth-1:0]       in_data_i,
  input  logic                       out_req_i,
  output logic                       out_ack_o,
  output logic [DataWidth-1:0]       out_data_o,
  output logic [$clog2(Depth):0]     occupancy_o,
`ifdef HS_FIFO_STATS_EN
  output logic [31:0]                tok_in_o,
  output logic [31:0]                tok_out_o,
  output logic [$clog2(Depth):0]     max_occ_o,
`endif
  output logic                       ovf_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = PtrW + 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]      occ_q, occ_d;
  logic                 in_req_q, in_req_d;
  logic                 out_ack_q, out_ack_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic                 ovf_q, ovf_d;
  logic                 push, pop;

  // Pop depends on pre-edge occupancy, so a token written this edge cannot be read this edge.
  assign push = in_ack_i & in_req_q;
  assign pop  = out_req_i & ~out_ack_q & (occ_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_ack_d  = 1'b0;
    out_data_d = out_data_q;
    ovf_d      = ovf_q | (in_ack_i & ~in_req_q);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      out_ack_d  = 1'b1;
      out_data_d = mem_q[rd_ptr_q];
    end
    occ_d    = occ_q + {{(OccW-1){1'b0}}, push} - {{(OccW-1){1'b0}}, pop};
    in_req_d = (occ_d < OccW'(Depth));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      in_req_q   <= 1'b0;
      out_ack_q  <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      in_req_q   <= in_req_d;
      out_ack_q  <= out_ack_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is not reset; stale slots are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

`ifdef HS_FIFO_STATS_EN
  logic [31:0]     tok_in_q, tok_out_q;
  logic [OccW-1:0] max_occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tok_in_q  <= '0;
      tok_out_q <= '0;
      max_occ_q <= '0;
    end else begin
      tok_in_q  <= tok_in_q + {31'd0, push};
      tok_out_q <= tok_out_q + {31'd0, pop};
      if (occ_d > max_occ_q) begin
        max_occ_q <= occ_d;
      end
    end
  end

  assign tok_in_o  = tok_in_q;
  assign tok_out_o = tok_out_q;
  assign max_occ_o = max_occ_q;
`endif

  assign in_req_o    = in_req_q;
  assign out_ack_o   = out_ack_q;
  assign out_data_o  = out_data_q;
  assign occupancy_o = occ_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_hs_token_fifo.sv
// Bench for hs_token_fifo: vector table, directed corner sequences and random traffic
// checked every cycle against a queue-based model of the token buffer.
module tb_hs_token_fifo;

  localparam int unsigned Dw    = 32;
  localparam int unsigned Depth = 4;
  localparam int unsigned OccW  = $clog2(Depth) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_ack = 1'b0;
  logic [Dw-1:0]   in_data = '0;
  logic            out_req = 1'b0;
  logic            in_req, out_ack, ovf;
  logic [Dw-1:0]   out_data;
  logic [OccW-1:0] occupancy;
`ifdef HS_FIFO_STATS_EN
  logic [31:0]     tok_in, tok_out;
  logic [OccW-1:0] max_occ;
`endif

  always #5 clk = ~clk;

  hs_token_fifo #(.DataWidth(Dw), .Depth(Depth)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_req_o    (in_req),
    .in_ack_i    (in_ack),
    .in_data_i   (in_data),
    .out_req_i   (out_req),
    .out_ack_o   (out_ack),
    .out_data_o  (out_data),
    .occupancy_o (occupancy),
`ifdef HS_FIFO_STATS_EN
    .tok_in_o    (tok_in),
    .tok_out_o   (tok_out),
    .max_occ_o   (max_occ),
`endif
    .ovf_o       (ovf)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: a token queue plus the handshake outputs it implies.
  logic [Dw-1:0] mq[$];
  logic          m_in_req = 1'b0, m_ack = 1'b0, m_ovf = 1'b0;
  logic [Dw-1:0] m_data = '0;
  int unsigned   m_tin = 0, m_tout = 0, m_max = 0;
  logic [Dw-1:0] rx[$];
  logic          prev_ack = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  task automatic model_edge();
    bit do_push, do_pop;
    if (rst) begin
      mq.delete();
      m_in_req = 0; m_ack = 0; m_data = '0; m_ovf = 0;
      m_tin = 0; m_tout = 0; m_max = 0;
      return;
    end
    do_push = in_ack && m_in_req;
    do_pop  = out_req && !m_ack && (mq.size() > 0);
    if (in_ack && !m_in_req) m_ovf = 1;
    m_ack = 0;
    if (do_pop) begin
      m_data = mq.pop_front();
      m_ack  = 1;
      m_tout++;
    end
    if (do_push) begin
      mq.push_back(in_data);
      m_tin++;
    end
    m_in_req = (mq.size() < Depth);
    if (mq.size() > m_max) m_max = mq.size();
  endtask

  task automatic check_all();
    chk("in_req", {31'd0, in_req}, {31'd0, m_in_req});
    chk("out_ack", {31'd0, out_ack}, {31'd0, m_ack});
    chk("out_data", out_data, m_data);
    chk("occupancy", {{(32-OccW){1'b0}}, occupancy}, mq.size());
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (out_ack && prev_ack) chk("ack_width", 32'd2, 32'd1);
    prev_ack = out_ack;
    if (out_ack) rx.push_back(out_data);
  endtask

  task automatic step(input logic r, input logic a, input logic [Dw-1:0] d, input logic o);
    @(negedge clk);
    rst = r; in_ack = a; in_data = d; out_req = o;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drain(input int want, input int budget);
    int n = 0;
    while (rx.size() < want && n < budget) begin
      step(0, 0, '0, 1);
      n++;
    end
    chk("drain_count", rx.size(), want);
  endtask

  typedef struct {
    logic          ack;
    logic [Dw-1:0] data;
    logic          oreq;
    logic          e_in_req;
    logic          e_ack;
    logic [Dw-1:0] e_data;
    int unsigned   e_occ;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 32'h0,  0, 1, 0, 32'h0,  0};
    vecs[1] = '{1, 32'hA5, 0, 1, 0, 32'h0,  1};
    vecs[2] = '{1, 32'hB6, 1, 1, 1, 32'hA5, 1};
    vecs[3] = '{0, 32'h0,  1, 1, 0, 32'hA5, 1};
    vecs[4] = '{0, 32'h0,  1, 1, 1, 32'hB6, 0};
    vecs[5] = '{0, 32'h0,  1, 1, 0, 32'hB6, 0};
    vecs[6] = '{0, 32'h0,  1, 1, 0, 32'hB6, 0};

    // Reset values
    step(1, 0, '0, 0);
    chk("rst_in_req", {31'd0, in_req}, 32'd0);
    chk("rst_occ", {{(32-OccW){1'b0}}, occupancy}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      step(0, vecs[i].ack, vecs[i].data, vecs[i].oreq);
      chk($sformatf("vec%0d_in_req", i), {31'd0, in_req}, {31'd0, vecs[i].e_in_req});
      chk($sformatf("vec%0d_ack", i), {31'd0, out_ack}, {31'd0, vecs[i].e_ack});
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
      chk($sformatf("vec%0d_occ", i), {{(32-OccW){1'b0}}, occupancy}, vecs[i].e_occ);
    end

    // Flow of 0..9 every other cycle with out_req held high
    step(1, 0, '0, 0);
    step(0, 0, '0, 1);
    rx.delete();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, i, 1);
      if (i == 0) chk("lat_k", {31'd0, out_ack}, 32'd0);
      step(0, 0, '0, 1);
      if (i == 0) chk("lat_k1", {out_ack, out_data[30:0]}, 32'h8000_0000);
    end
    drain(10, 20);
    for (int i = 0; i < 10; i++) chk($sformatf("flow_tok%0d", i), rx[i], i);
    chk("flow_ovf", {31'd0, ovf}, 32'd0);
    chk("flow_occ", {{(32-OccW){1'b0}}, occupancy}, 32'd0);
`ifdef HS_FIFO_STATS_EN
    chk("stat_tok_in", tok_in, 32'd10);
    chk("stat_tok_out", tok_out, 32'd10);
    chk("stat_max_occ_ge1", {31'd0, (max_occ >= 1)}, 32'd1);
    chk("stat_max_occ", {{(32-OccW){1'b0}}, max_occ}, m_max);
`endif

    // Fill to full, then overflow while full
    step(0, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 10 + i, 0);
    chk("full_occ", {{(32-OccW){1'b0}}, occupancy}, 32'd4);
    chk("full_in_req", {31'd0, in_req}, 32'd0);
    step(0, 1, 99, 0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_occ", {{(32-OccW){1'b0}}, occupancy}, 32'd4);
    rx.delete();
    step(0, 0, '0, 1);
    chk("pop_first", out_data, 32'd10);
    chk("pop_in_req", {31'd0, in_req}, 32'd1);
    drain(4, 12);
    for (int i = 0; i < 4; i++) chk($sformatf("full_tok%0d", i), rx[i], 10 + i);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    chk("no_99", {{(32-OccW){1'b0}}, occupancy}, 32'd0);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Reset mid-stream at occupancy 3
    for (int i = 0; i < 3; i++) step(0, 1, 20 + i, 0);
    chk("pre_rst_occ", {{(32-OccW){1'b0}}, occupancy}, 32'd3);
    step(1, 0, '0, 0);
    chk("mid_rst_occ", {{(32-OccW){1'b0}}, occupancy}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_in_req", {31'd0, in_req}, 32'd0);
    step(0, 0, '0, 0);
    rx.delete();
    step(0, 1, 30, 1);
    drain(1, 6);
    chk("fresh_tok", rx[0], 32'd30);

    // Simultaneous push/pop at occupancy 2, 20 tokens through the pointer wrap
    step(0, 0, '0, 0);
    rx.delete();
    step(0, 1, 40, 0);
    step(0, 1, 41, 0);
    for (int t = 42; t < 60; t++) begin
      step(0, 1, t, 1);
      chk("simul_occ", {{(32-OccW){1'b0}}, occupancy}, 32'd2);
      step(0, 0, '0, 1);
    end
    drain(20, 12);
    for (int i = 0; i < 20; i++) chk($sformatf("wrap_tok%0d", i), rx[i], 40 + i);

    // Random traffic
    step(1, 0, '0, 0);
    for (int i = 0; i < 400; i++) begin
      step(0, ($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 45));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hs_token_fifo.md
# hs_token_fifo

Elastic token buffer for the req/ack dataflow fabric. It sits directly downstream of an `out` async operator (or any ack-pulse source) and upstream of a consumer, absorbing rate mismatch between them. Toward its upstream it behaves as a consumer: it raises `in_req` and accepts one token per `in_ack` pulse. Toward its downstream it behaves as a producer: it answers `out_req` with one-cycle `out_ack` pulses carrying data.

## Interface
- `data_width`, 32, token width in bits.
- `depth`, 4, storage slots; power of two, ≥2.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high; clock is `clk`.
- `in_req`  out  1  request to upstream; registered.
- `in_ack`  in  1  upstream delivery pulse; one token per cycle sampled high.
- `in_data`  in  data_width  token; valid in the cycle `in_ack`=1.
- `out_req`  in  1  downstream request (level).
- `out_ack`  out  1  delivery pulse to downstream; registered.
- `out_data`  out  data_width  token; valid while `out_ack`=1, held otherwise.
- `occupancy`  out  $clog2(depth)+1  stored tokens, 0..depth.
- `ovf`  out  1  sticky: token arrived while `in_req` was low (token dropped).

## Operation
- Storage: circular array; `wr_ptr`/`rd_ptr` are $clog2(depth) bits and wrap modulo depth. Occupancy is a separate counter.
- push = `in_ack` & `in_req`. On push, write `in_data` at `wr_ptr` and increment the pointer.
- `in_ack` & ~`in_req`: no write; set `ovf`. Only `rst` clears `ovf`.
- pop condition = `out_req` & ~`out_ack` & (occupancy>0).
- On pop: `out_ack`<=1, `out_data`<=mem[`rd_ptr`], increment `rd_ptr`.
- Otherwise `out_ack`<=0 and `out_data` holds.
- occ_next = occupancy + push − pop. Register `occupancy`<=occ_next.
- `in_req`<=(occ_next<depth). It therefore drops at the same edge that the last free slot is filled.
- Simultaneous push+pop: occupancy unchanged and both pointers advance. At occupancy=depth no push is possible because `in_req` is low, so a pop frees a slot and `in_req` rises at that edge.
- A token written at edge k is never read at edge k. The read uses pre-edge occupancy, so there is no write-through.
- No other state machine: per-slot state is full or empty, tracked by the pointers and the counter.

## Timing
- Reset values: `in_req`=0, `out_ack`=0, `out_data`=0, `occupancy`=0, `ovf`=0, pointers=0.
- Reset mid-operation flushes all stored tokens; memory contents are don't-care.
- First edge after reset release: `in_req`<=1.
- Latency: `in_ack` sampled at edge k with the buffer empty and `out_req` high gives `out_ack` high in the cycle after edge k+1. That is 2 cycles, with `out_data`=that token.
- Downstream throughput: at most 1 token per 2 cycles, because of the ~`out_ack` term, matching the consumer/producer pulse discipline.
- Upstream throughput: 1 token per cycle while not full.
- `out_ack` is never high for two consecutive cycles.
- Full: occupancy=depth implies `in_req`=0 from the same edge.
- Empty: occupancy=0 implies no `out_ack`, even when `out_req` is held high.

## Configuration
- `HS_FIFO_STATS_EN` defined adds three outputs:
  - `tok_in` (32 bit): count of pushes.
  - `tok_out` (32 bit): count of pops.
  - `max_occ` ($clog2(depth)+1): high-water mark of `occupancy`.
- All three reset to 0 and wrap modulo 2^32 (the counters).
- Not defined: these ports and their logic are absent. Datapath behaviour is identical in both cases.

## Test plan
- Reset then flow, depth=4: source pulses `in_ack` with data 0..9 every other cycle, `out_req` held 1. Sink sees 0..9 in order, each `out_ack` 1 cycle wide, `ovf`=0, final `occupancy`=0.
- Fill to full: 4 pushes (values 10,11,12,13) with `out_req`=0. `occupancy`=4, and `in_req` falls at the 4th push edge. Raise `out_req`: 10 is delivered first, and `in_req` rises at the pop edge.
- Overflow: while full, force `in_ack`=1 with data 99. `ovf`=1, `occupancy` stays 4, and 99 is never delivered. `ovf` stays 1 until `rst`.
- Simultaneous push/pop at occupancy=2: `occupancy` stays 2 and ordering is preserved. Run 20 tokens to exercise pointer wrap (>2× depth) and check the sequence stays monotonic.
- Reset mid-stream: assert `rst` for 1 cycle with `occupancy`=3. All outputs are at reset values next cycle, and post-reset tokens start fresh with no stale data.
- `HS_FIFO_STATS_EN`: after the 10-token flow, `tok_in`=10, `tok_out`=10, `max_occ` ≥1. Without the macro, the build has no stats ports.
